// File: rtl/jtag_multichain_data_register_if.sv
// Scan/data bundle for the multichain JTAG data register.
// master drives enables, select, NDI, TDI, MODE; slave returns NDO, TDO, UPDATE_DONE, LEN_ERR.
interface jtag_multichain_data_register_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CHAINS = 4,
    parameter int SEL_WIDTH  = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
);
    logic                             CAPTURE_DR;
    logic                             SHIFT_DR;
    logic                             UPDATE_DR;
    logic [SEL_WIDTH-1:0]             CHAIN_SEL;
    logic [NUM_CHAINS*DATA_WIDTH-1:0] NDI;
    logic                             TDI;
    logic [NUM_CHAINS-1:0]            MODE;
    logic [NUM_CHAINS*DATA_WIDTH-1:0] NDO;
    logic                             TDO;
    logic                             UPDATE_DONE;
    logic                             LEN_ERR;

    modport master (
        output CAPTURE_DR, SHIFT_DR, UPDATE_DR, CHAIN_SEL, NDI, TDI, MODE,
        input  NDO, TDO, UPDATE_DONE, LEN_ERR
    );

    modport slave (
        input  CAPTURE_DR, SHIFT_DR, UPDATE_DR, CHAIN_SEL, NDI, TDI, MODE,
        output NDO, TDO, UPDATE_DONE, LEN_ERR
    );
endinterface

// File: rtl/jtag_multichain_data_register.sv
// NUM_CHAINS scan chains behind one TDI/TDO pair, 1-bit bypass for bad selects.
// Ports: CLOCK, RESET (sync, active high), bus (slave side of the scan bundle).
module jtag_multichain_data_register #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    NUM_CHAINS    = 4,
    parameter int                    SEL_WIDTH     = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0,
    parameter bit                    STRICT_LENGTH = 1'b1
) (
    input logic                            CLOCK,
    input logic                            RESET,
    jtag_multichain_data_register_if.slave bus
);
    localparam int                    CW       = $clog2(DATA_WIDTH + 2);
    localparam logic [CW-1:0]         CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0]         CNT_SAT  = CW'(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sr_q  [NUM_CHAINS];
    logic [DATA_WIDTH-1:0] sr_d  [NUM_CHAINS];
    logic [DATA_WIDTH-1:0] upd_q [NUM_CHAINS];
    logic [DATA_WIDTH-1:0] upd_d [NUM_CHAINS];
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  sel_valid_q, sel_valid_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  byp_q, byp_d;
    logic                  len_err_q, len_err_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0]            cur_sr;
    logic                             upd_ok;
    logic [NUM_CHAINS*DATA_WIDTH-1:0] ndo;

    // Shift register of the chain latched at the last capture.
    always_comb begin
        cur_sr = '0;
        for (int k = 0; k < NUM_CHAINS; k++) begin
            if (sel_q == SEL_WIDTH'(k)) begin
                cur_sr = sr_q[k];
            end
        end
    end

    always_comb begin
        sr_d        = sr_q;
        upd_d       = upd_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        cnt_d       = cnt_q;
        byp_d       = byp_q;
        len_err_d   = len_err_q;
        done_d      = 1'b0;
        upd_ok      = sel_valid_q && (!STRICT_LENGTH || cnt_q == CNT_FULL);

        if (bus.CAPTURE_DR) begin
            sel_d       = bus.CHAIN_SEL;
            sel_valid_d = (32'(bus.CHAIN_SEL) < NUM_CHAINS);
            cnt_d       = '0;
            len_err_d   = 1'b0;
            if (sel_valid_d) begin
                for (int k = 0; k < NUM_CHAINS; k++) begin
                    if (bus.CHAIN_SEL == SEL_WIDTH'(k)) begin
                        sr_d[k] = bus.NDI[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end else begin
                byp_d = 1'b0;
            end
        end else if (bus.SHIFT_DR) begin
            if (sel_valid_q) begin
                // LSB leaves on TDO, TDI enters at the MSB.
                for (int k = 0; k < NUM_CHAINS; k++) begin
                    if (sel_q == SEL_WIDTH'(k)) begin
                        sr_d[k] = (sr_q[k] >> 1) | (bus.TDI ? MSB_ONE : '0);
                    end
                end
            end else begin
                byp_d = bus.TDI;
            end
            // Saturate one past full so over-length shifts stay detectable.
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (bus.UPDATE_DR) begin
            if (upd_ok) begin
                for (int k = 0; k < NUM_CHAINS; k++) begin
                    if (sel_q == SEL_WIDTH'(k)) begin
                        upd_d[k] = sr_q[k];
                    end
                end
                done_d = 1'b1;
            end else if (sel_valid_q) begin
                len_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int k = 0; k < NUM_CHAINS; k++) begin
                sr_q[k]  <= RESET_VALUE;
                upd_q[k] <= RESET_VALUE;
            end
            sel_q       <= '0;
            sel_valid_q <= 1'b1;
            cnt_q       <= '0;
            byp_q       <= 1'b0;
            len_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            upd_q       <= upd_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            cnt_q       <= cnt_d;
            byp_q       <= byp_d;
            len_err_q   <= len_err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        ndo = '0;
        for (int k = 0; k < NUM_CHAINS; k++) begin
            ndo[k*DATA_WIDTH +: DATA_WIDTH] = bus.MODE[k] ? upd_q[k]
                                            : bus.NDI[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // TDO comes from flops only; TDI never reaches it combinationally.
    assign bus.TDO         = sel_valid_q ? cur_sr[0] : byp_q;
    assign bus.NDO         = ndo;
    assign bus.UPDATE_DONE = done_q;
    assign bus.LEN_ERR     = len_err_q;
endmodule

// File: tb/tb_jtag_multichain_data_register.sv
// Bench for jtag_multichain_data_register: directed table, corner sequences, random vs model.
// Three instances share stimulus: 4 chains strict, 4 chains non-strict, 3 chains strict.
module tb_jtag_multichain_data_register;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cap = 1'b0;
    logic        sh  = 1'b0;
    logic        up  = 1'b0;
    logic [1:0]  sel = '0;
    logic        tdi = 1'b0;
    logic [31:0] ndi = '0;
    logic [3:0]  mode = '0;

    int checks = 0;
    int errors = 0;
    bit mchk   = 1'b0;

    always #5 clk = ~clk;

    jtag_multichain_data_register_if #(.DATA_WIDTH(8), .NUM_CHAINS(4)) b4 ();
    jtag_multichain_data_register_if #(.DATA_WIDTH(8), .NUM_CHAINS(4)) bn ();
    jtag_multichain_data_register_if #(.DATA_WIDTH(8), .NUM_CHAINS(3)) b3 ();

    assign b4.CAPTURE_DR = cap;
    assign b4.SHIFT_DR   = sh;
    assign b4.UPDATE_DR  = up;
    assign b4.CHAIN_SEL  = sel;
    assign b4.NDI        = ndi;
    assign b4.TDI        = tdi;
    assign b4.MODE       = mode;
    assign bn.CAPTURE_DR = cap;
    assign bn.SHIFT_DR   = sh;
    assign bn.UPDATE_DR  = up;
    assign bn.CHAIN_SEL  = sel;
    assign bn.NDI        = ndi;
    assign bn.TDI        = tdi;
    assign bn.MODE       = mode;
    assign b3.CAPTURE_DR = cap;
    assign b3.SHIFT_DR   = sh;
    assign b3.UPDATE_DR  = up;
    assign b3.CHAIN_SEL  = sel;
    assign b3.NDI        = ndi[23:0];
    assign b3.TDI        = tdi;
    assign b3.MODE       = mode[2:0];

    jtag_multichain_data_register #(
        .DATA_WIDTH(8), .NUM_CHAINS(4), .STRICT_LENGTH(1'b1)
    ) dut4 (.CLOCK(clk), .RESET(rst), .bus(b4));

    jtag_multichain_data_register #(
        .DATA_WIDTH(8), .NUM_CHAINS(4), .STRICT_LENGTH(1'b0)
    ) dutn (.CLOCK(clk), .RESET(rst), .bus(bn));

    jtag_multichain_data_register #(
        .DATA_WIDTH(8), .NUM_CHAINS(3), .STRICT_LENGTH(1'b1)
    ) dut3 (.CLOCK(clk), .RESET(rst), .bus(b3));

    // Reference model: chains as byte arrays, shift count as a plain integer.
    typedef struct packed {
        logic [3:0][7:0] sr;
        logic [3:0][7:0] upd;
        int              sel;
        bit              valid;
        int              cnt;
        bit              byp;
        bit              lerr;
        bit              done;
    } mstate_t;

    mstate_t m4, mn, m3;

    function automatic mstate_t mstep(mstate_t s, int nch, bit strict);
        mstate_t n = s;
        n.done = 1'b0;
        if (rst) begin
            n = '0;
            n.valid = 1'b1;
        end else if (cap) begin
            n.sel   = int'(sel);
            n.valid = (int'(sel) < nch);
            if (n.valid) n.sr[n.sel] = ndi[n.sel*8 +: 8];
            else n.byp = 1'b0;
            n.cnt  = 0;
            n.lerr = 1'b0;
        end else if (sh) begin
            if (s.valid) n.sr[s.sel] = (s.sr[s.sel] >> 1) + (tdi ? 8'd128 : 8'd0);
            else n.byp = tdi;
            n.cnt = (s.cnt + 1 > 9) ? 9 : s.cnt + 1;
        end else if (up) begin
            if (s.valid && (!strict || s.cnt == 8)) begin
                n.upd[s.sel] = s.sr[s.sel];
                n.done = 1'b1;
            end else if (s.valid) begin
                n.lerr = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic mtdo(mstate_t s);
        logic [7:0] c = s.sr[s.sel];
        return s.valid ? c[0] : s.byp;
    endfunction

    function automatic logic [31:0] mndo(mstate_t s);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = mode[k] ? s.upd[k] : ndi[k*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, a, e);
        end
    endtask

    task automatic compare_all();
        chk("rnd_tdo4",  32'(b4.TDO), 32'(mtdo(m4)));
        chk("rnd_done4", 32'(b4.UPDATE_DONE), 32'(m4.done));
        chk("rnd_lerr4", 32'(b4.LEN_ERR), 32'(m4.lerr));
        chk("rnd_ndo4",  b4.NDO, mndo(m4));
        chk("rnd_tdon",  32'(bn.TDO), 32'(mtdo(mn)));
        chk("rnd_donen", 32'(bn.UPDATE_DONE), 32'(mn.done));
        chk("rnd_lerrn", 32'(bn.LEN_ERR), 32'(mn.lerr));
        chk("rnd_ndon",  bn.NDO, mndo(mn));
        chk("rnd_tdo3",  32'(b3.TDO), 32'(mtdo(m3)));
        chk("rnd_done3", 32'(b3.UPDATE_DONE), 32'(m3.done));
        chk("rnd_lerr3", 32'(b3.LEN_ERR), 32'(m3.lerr));
        chk("rnd_ndo3",  32'(b3.NDO), 32'(mndo(m3) & 32'h00FF_FFFF));
    endtask

    task automatic step(input bit r, input bit c, input bit s, input bit u,
                        input logic [1:0] sl, input bit t);
        rst = r; cap = c; sh = s; up = u; sel = sl; tdi = t;
        @(posedge clk);
        m4 = mstep(m4, 4, 1'b1);
        mn = mstep(mn, 4, 1'b0);
        m3 = mstep(m3, 3, 1'b1);
        #1;
        if (mchk) compare_all();
    endtask

    typedef struct {
        bit          r, c, s, u;
        logic [1:0]  sl;
        bit          t;
        logic [31:0] nd;
        logic [3:0]  md;
        bit          et, ed, el;
        logic [31:0] en;
    } vec_t;

    vec_t tv[$];
    localparam logic [31:0] N = 32'h44A5_2211;

    task automatic row(input bit r, c, s, u, input logic [1:0] sl, input bit t,
                       input logic [31:0] nd, input logic [3:0] md,
                       input bit et, ed, el, input logic [31:0] en);
        vec_t v;
        v.r = r; v.c = c; v.s = s; v.u = u; v.sl = sl; v.t = t;
        v.nd = nd; v.md = md; v.et = et; v.ed = ed; v.el = el; v.en = en;
        tv.push_back(v);
    endtask

    task automatic shr(input bit t, input bit et, input bit el, input logic [31:0] en);
        row(0, 0, 1, 0, 2'd0, t, N, 4'hF, et, 0, el, en);
    endtask

    initial begin
        int n;
        // Reset, capture chain 2 (A5), shift in 3C, update.
        row(1, 0, 0, 0, 2'd0, 0, N, 4'hF, 0, 0, 0, 32'h0);
        row(0, 1, 0, 0, 2'd2, 0, N, 4'hF, 1, 0, 0, 32'h0);
        shr(0, 0, 0, 32'h0); shr(0, 1, 0, 32'h0);
        shr(1, 0, 0, 32'h0); shr(1, 0, 0, 32'h0);
        shr(1, 1, 0, 32'h0); shr(1, 0, 0, 32'h0);
        shr(0, 1, 0, 32'h0); shr(0, 0, 0, 32'h0);
        row(0, 0, 0, 1, 2'd2, 0, N, 4'hF, 0, 1, 0, 32'h003C_0000);
        row(0, 0, 0, 0, 2'd2, 0, N, 4'hF, 0, 0, 0, 32'h003C_0000);
        // Chain 1, seven shifts: rejected.
        row(0, 1, 0, 0, 2'd1, 0, N, 4'hF, 0, 0, 0, 32'h003C_0000);
        shr(1, 1, 0, 32'h003C_0000); shr(1, 0, 0, 32'h003C_0000);
        shr(1, 0, 0, 32'h003C_0000); shr(1, 0, 0, 32'h003C_0000);
        shr(1, 1, 0, 32'h003C_0000); shr(1, 0, 0, 32'h003C_0000);
        shr(1, 0, 0, 32'h003C_0000);
        row(0, 0, 0, 1, 2'd1, 0, N, 4'hF, 0, 0, 1, 32'h003C_0000);
        row(0, 0, 0, 0, 2'd1, 0, N, 4'hF, 0, 0, 1, 32'h003C_0000);
        // Recapture clears LEN_ERR; nine shifts also rejected.
        row(0, 1, 0, 0, 2'd1, 0, N, 4'hF, 0, 0, 0, 32'h003C_0000);
        shr(0, 1, 0, 32'h003C_0000); shr(0, 0, 0, 32'h003C_0000);
        shr(0, 0, 0, 32'h003C_0000); shr(0, 0, 0, 32'h003C_0000);
        shr(0, 1, 0, 32'h003C_0000); shr(0, 0, 0, 32'h003C_0000);
        shr(0, 0, 0, 32'h003C_0000); shr(0, 0, 0, 32'h003C_0000);
        shr(0, 0, 0, 32'h003C_0000);
        row(0, 0, 0, 1, 2'd1, 0, N, 4'hF, 0, 0, 1, 32'h003C_0000);
        // Capture+shift together: capture only, so 8 more shifts is exact.
        row(0, 1, 1, 0, 2'd0, 1, N, 4'hF, 1, 0, 0, 32'h003C_0000);
        shr(1, 0, 0, 32'h003C_0000); shr(1, 0, 0, 32'h003C_0000);
        shr(1, 0, 0, 32'h003C_0000); shr(1, 1, 0, 32'h003C_0000);
        shr(1, 0, 0, 32'h003C_0000); shr(1, 0, 0, 32'h003C_0000);
        shr(1, 0, 0, 32'h003C_0000); shr(1, 1, 0, 32'h003C_0000);
        row(0, 0, 0, 1, 2'd0, 0, N, 4'hF, 1, 1, 0, 32'h003C_00FF);
        // Shift beats update.
        row(0, 0, 1, 1, 2'd0, 0, N, 4'hF, 1, 0, 0, 32'h003C_00FF);
        // MODE mux follows NDI combinationally.
        row(0, 0, 0, 0, 2'd0, 0, 32'h44A5_2200, 4'hE, 1, 0, 0, 32'h003C_0000);
        row(0, 0, 0, 0, 2'd0, 0, 32'h44A5_225A, 4'hE, 1, 0, 0, 32'h003C_005A);
        row(0, 0, 0, 0, 2'd0, 0, 32'h44A5_225A, 4'hF, 1, 0, 0, 32'h003C_00FF);
        row(0, 0, 0, 0, 2'd0, 0, 32'h44A5_225A, 4'h0, 1, 0, 0, 32'h44A5_225A);
        // Reset mid-shift, then update without capture is rejected.
        row(0, 1, 0, 0, 2'd3, 0, N, 4'hF, 0, 0, 0, 32'h003C_00FF);
        shr(1, 0, 0, 32'h003C_00FF); shr(1, 1, 0, 32'h003C_00FF);
        shr(1, 0, 0, 32'h003C_00FF); shr(1, 0, 0, 32'h003C_00FF);
        row(1, 0, 0, 0, 2'd0, 0, N, 4'hF, 0, 0, 0, 32'h0);
        row(0, 0, 0, 1, 2'd0, 0, N, 4'hF, 0, 0, 1, 32'h0);

        foreach (tv[i]) begin
            ndi  = tv[i].nd;
            mode = tv[i].md;
            step(tv[i].r, tv[i].c, tv[i].s, tv[i].u, tv[i].sl, tv[i].t);
            chk($sformatf("v%0d_tdo", i),  32'(b4.TDO), 32'(tv[i].et));
            chk($sformatf("v%0d_done", i), 32'(b4.UPDATE_DONE), 32'(tv[i].ed));
            chk($sformatf("v%0d_lerr", i), 32'(b4.LEN_ERR), 32'(tv[i].el));
            chk($sformatf("v%0d_ndo", i),  b4.NDO, tv[i].en);
        end

        // Three-chain instance: select 3 is out of range, one-bit bypass.
        ndi = N; mode = 4'hF;
        step(0, 1, 0, 0, 2'd3, 0);
        chk("byp_cap_tdo", 32'(b3.TDO), 32'd0);
        step(0, 0, 1, 0, 2'd3, 1);
        chk("byp_s1_tdo", 32'(b3.TDO), 32'd1);
        step(0, 0, 1, 0, 2'd3, 1);
        chk("byp_s2_tdo", 32'(b3.TDO), 32'd1);
        step(0, 0, 1, 0, 2'd3, 0);
        chk("byp_s3_tdo", 32'(b3.TDO), 32'd0);
        step(0, 0, 0, 1, 2'd3, 0);
        chk("byp_upd_done", 32'(b3.UPDATE_DONE), 32'd0);
        chk("byp_upd_lerr", 32'(b3.LEN_ERR), 32'd0);
        chk("byp_upd_ndo", 32'(b3.NDO), 32'd0);

        // Non-strict instance accepts seven shifts; strict one rejects.
        step(0, 1, 0, 0, 2'd1, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 2'd1, 1);
        step(0, 0, 0, 1, 2'd1, 0);
        chk("ns_done", 32'(bn.UPDATE_DONE), 32'd1);
        chk("ns_ndo1", 32'(bn.NDO[15:8]), 32'hFE);
        chk("st_lerr", 32'(b4.LEN_ERR), 32'd1);
        chk("st_done", 32'(b4.UPDATE_DONE), 32'd0);
        step(0, 0, 0, 0, 2'd1, 0);
        chk("ns_done_pulse", 32'(bn.UPDATE_DONE), 32'd0);

        // Random episodes against the model.
        mchk = 1'b1;
        for (int e = 0; e < 150; e++) begin
            ndi = $urandom; mode = 4'($urandom);
            if ($urandom_range(0, 15) == 0) step(1, 0, 0, 0, 2'd0, 0);
            step(0, 1, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            n = ($urandom_range(0, 1) == 0) ? 8 : $urandom_range(0, 11);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    ndi = $urandom; mode = 4'($urandom);
                end
                step(($urandom_range(0, 199) == 0), 1'b0, 1'b1,
                     ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom));
            end
            step(0, 0, 0, 1, 2'($urandom), 1'($urandom));
            step(0, 0, 0, 0, 2'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_multichain_data_register.md
Name: jtag_multichain_data_register

Overview:
- Next-generation JTAG test data register for the RD53A EOC JTAG block.
- Provides NUM_CHAINS independent boundary-scan style chains, each DATA_WIDTH bits wide, behind one TDI/TDO pair.
- Chain selected at capture time; out-of-range select falls back to a 1-bit bypass.
- Single-clock, enable-driven (no gated CLOCK_DR/UPDATE_DR); adds shift-length checking that blocks corrupted updates.

Parameters:
DATA_WIDTH, 8, bits per chain (>=1)
NUM_CHAINS, 4, number of chains (>=1)
SEL_WIDTH, $clog2(NUM_CHAINS) (min 1), width of CHAIN_SEL
RESET_VALUE, 0 (DATA_WIDTH bits), reset value of every shift and update register
STRICT_LENGTH, 1, 1 = update only after exactly DATA_WIDTH shifts; 0 = update always

Ports:
CLOCK  in  1  system/TCK-domain clock, all state on rising edge
RESET  in  1  synchronous, active-high reset
CAPTURE_DR  in  1  one-cycle capture enable
SHIFT_DR  in  1  shift enable, one bit per cycle
UPDATE_DR  in  1  one-cycle update enable
CHAIN_SEL  in  SEL_WIDTH  chain index, sampled on CAPTURE_DR
NDI  in  NUM_CHAINS*DATA_WIDTH  normal data-in, chain k at [k*DATA_WIDTH +: DATA_WIDTH]
TDI  in  1  scan input
MODE  in  NUM_CHAINS  per-chain output mux select (1 = drive update register)
NDO  out  NUM_CHAINS*DATA_WIDTH  normal data-out, same packing as NDI
TDO  out  1  scan output
UPDATE_DONE  out  1  one-cycle pulse, accepted update
LEN_ERR  out  1  sticky: update rejected for wrong shift count

Behaviour:
- Reset (synchronous, CLOCK edge with RESET=1):
  - all shift regs sr[k] and update regs upd[k] = RESET_VALUE
  - sel_q = 0, sel_valid = 1, shift counter cnt = 0, bypass FF = 0
  - LEN_ERR = 0, UPDATE_DONE = 0
  - Reset wins over all enables, including mid-shift.
- Priority when enables coincide: CAPTURE_DR > SHIFT_DR > UPDATE_DR. Lower-priority enables are ignored that cycle.
- Capture:
  - sel_q <= CHAIN_SEL.
  - sel_valid <= (CHAIN_SEL < NUM_CHAINS).
  - If valid: sr[CHAIN_SEL] <= NDI slice; otherwise bypass FF <= 0.
  - cnt <= 0; LEN_ERR <= 0.
- Shift:
  - If sel_valid: sr[sel_q] <= {TDI, sr[sel_q][DATA_WIDTH-1:1]} (LSB out first). Otherwise bypass FF <= TDI.
  - cnt increments, saturating at DATA_WIDTH+1 (width $clog2(DATA_WIDTH+2)).
- Update:
  - Accepted if sel_valid and (STRICT_LENGTH==0 or cnt==DATA_WIDTH).
  - Accepted: upd[sel_q] <= sr[sel_q]; UPDATE_DONE = 1 on the following cycle only.
  - Rejected, sel_valid=1: upd unchanged, no UPDATE_DONE, LEN_ERR <= 1 (sticky until next capture or reset).
  - Rejected, sel_valid=0 (bypass): no register change, no LEN_ERR.
- Unselected chains hold sr and upd unconditionally.
- TDO: combinational from registers only. sel_valid ? sr[sel_q][0] : bypass FF. No path from TDI to TDO.
- NDO slice k = MODE[k] ? upd[k] : NDI slice k (combinational, per chain).
- CHAIN_SEL changes between captures have no effect.

Test Plan:
1. Reset with MODE=4'hF, RESET_VALUE=0 -> NDO all zero, TDO=0, LEN_ERR=0, UPDATE_DONE=0.
2. CHAIN_SEL=2, NDI chain2=8'hA5, capture; 8 shifts with TDI=8'h3C LSB-first -> TDO sequence 1,0,1,0,0,1,0,1. Then update -> upd[2]=8'h3C, NDO chain2=8'h3C, UPDATE_DONE high exactly one cycle after update, chains 0/1/3 unchanged.
3. CHAIN_SEL=1, capture, 7 shifts, update -> upd[1] unchanged, LEN_ERR=1, no UPDATE_DONE. Next capture -> LEN_ERR=0. Repeat with 9 shifts -> also rejected. With STRICT_LENGTH=0, 7 shifts -> accepted.
4. NUM_CHAINS=3, CHAIN_SEL=3, capture, shift TDI=1,1,0 -> TDO=0,1,1 (one-cycle bypass). Update -> no upd change, no UPDATE_DONE, LEN_ERR=0.
5. CAPTURE_DR and SHIFT_DR asserted together -> only capture (sr = NDI, cnt=0). RESET asserted after 4 of 8 shifts -> all defaults. A following update without capture (cnt=0) -> rejected, LEN_ERR=1.
6. MODE[0]=0, NDI chain0 toggled 8'h00->8'hFF -> NDO chain0 follows the same cycle. MODE[0]=1 -> NDO chain0 = upd[0] regardless of NDI.
